// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states and decode helpers.
package alu_mdu_pkg;

   localparam int unsigned OP_MULT  = 20;
   localparam int unsigned OP_MULTU = 21;
   localparam int unsigned OP_DIV   = 22;
   localparam int unsigned OP_DIVU  = 23;
   localparam int unsigned OP_MFHI  = 24;
   localparam int unsigned OP_MFLO  = 25;
   localparam int unsigned OP_MTHI  = 26;
   localparam int unsigned OP_MTLO  = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } state_t;

   // Any opcode owned by the MDU (long ops and HI/LO moves)
   function automatic logic is_mdu_op(input int unsigned op);
      return (op >= OP_MULT) && (op <= OP_MTLO);
   endfunction

   // Opcodes that start a multi-cycle operation
   function automatic logic is_long_op(input int unsigned op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_seq_core.sv
// Shared 2*N_BITS shift register: shift-add multiply or restoring divide, one bit per step.
module mdu_seq_core #(
   parameter int unsigned N_BITS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [N_BITS-1:0] load_lo,
   input  logic [N_BITS-1:0] load_op,
   output logic [N_BITS-1:0] acc_hi,
   output logic [N_BITS-1:0] acc_lo
);

   logic [N_BITS-1:0] hi_q, lo_q, op_q;
   logic [N_BITS-1:0] hi_nxt, lo_nxt;
   logic [N_BITS:0]   add_sum;
   logic [N_BITS:0]   rem_shift;

   // hi holds partial product / remainder, lo holds multiplier / dividend-quotient
   always_comb begin
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      add_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
      rem_shift = {hi_q, lo_q[N_BITS-1]};
      if (is_div) begin
         if (rem_shift >= {1'b0, op_q}) begin
            hi_nxt = N_BITS'(rem_shift - {1'b0, op_q});
            lo_nxt = {lo_q[N_BITS-2:0], 1'b1};
         end else begin
            hi_nxt = rem_shift[N_BITS-1:0];
            lo_nxt = {lo_q[N_BITS-2:0], 1'b0};
         end
      end else begin
         {hi_nxt, lo_nxt} = {add_sum, lo_q[N_BITS-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         op_q <= '0;
      end else if (load) begin
         hi_q <= '0;
         lo_q <= load_lo;
         op_q <= load_op;
      end else if (step) begin
         hi_q <= hi_nxt;
         lo_q <= lo_nxt;
      end
   end

   assign acc_hi = hi_q;
   assign acc_lo = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers: FSM, sign handling and MF/MT paths.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int unsigned N_BITS   = 32,
   parameter int unsigned N_OPCODE = 6
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [N_OPCODE-1:0] i_opcode,
   input  logic [N_BITS-1:0]   i_datoA,
   input  logic [N_BITS-1:0]   i_datoB,
   output logic [N_BITS-1:0]   o_hi,
   output logic [N_BITS-1:0]   o_lo,
   output logic [N_BITS-1:0]   o_result,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_stall
);

   localparam int unsigned CNT_W = $clog2(N_BITS);

   state_t            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic [N_BITS-1:0] hi_q, hi_nxt, lo_q, lo_nxt;
   logic              busy_q, busy_nxt, done_q, done_nxt;
   logic              is_div_q, is_div_nxt;
   logic              neg_q_q, neg_q_nxt, neg_r_q, neg_r_nxt;

   logic              accept, op_div, op_signed, a_msb, b_msb, b_zero;
   logic [N_BITS-1:0] a_mag, b_mag, acc_hi, acc_lo;
   logic [2*N_BITS-1:0] prod, prod_neg;
   logic              core_load, core_step;

   assign accept    = i_valid && (state_q == ST_IDLE) && is_long_op(32'(i_opcode));
   assign op_div    = (i_opcode == N_OPCODE'(OP_DIV)) || (i_opcode == N_OPCODE'(OP_DIVU));
   assign op_signed = (i_opcode == N_OPCODE'(OP_MULT)) || (i_opcode == N_OPCODE'(OP_DIV));
   assign a_msb     = i_datoA[N_BITS-1];
   assign b_msb     = i_datoB[N_BITS-1];
   assign b_zero    = (i_datoB == '0);
   assign a_mag     = (op_signed && a_msb) ? -i_datoA : i_datoA;
   assign b_mag     = (op_signed && b_msb) ? -i_datoB : i_datoB;
   assign prod      = {acc_hi, acc_lo};
   assign prod_neg  = -prod;

   mdu_seq_core #(.N_BITS(N_BITS)) u_core (
      .clk     (i_clock),
      .rst     (i_reset),
      .load    (core_load),
      .step    (core_step),
      .is_div  (is_div_q),
      .load_lo (op_div ? a_mag : b_mag),
      .load_op (op_div ? b_mag : a_mag),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo)
   );

   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      hi_nxt     = hi_q;
      lo_nxt     = lo_q;
      is_div_nxt = is_div_q;
      neg_q_nxt  = neg_q_q;
      neg_r_nxt  = neg_r_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               core_load  = 1'b1;
               cnt_nxt    = CNT_W'(N_BITS - 1);
               is_div_nxt = op_div;
               // Divide by zero keeps the raw all-ones quotient; remainder sign restores A
               neg_q_nxt  = op_signed && (a_msb ^ b_msb) && !(op_div && b_zero);
               neg_r_nxt  = op_signed && a_msb;
               state_nxt  = op_div ? ST_DIV : ST_MUL;
            end else if (i_valid && (i_opcode == N_OPCODE'(OP_MTHI))) begin
               hi_nxt = i_datoA;
            end else if (i_valid && (i_opcode == N_OPCODE'(OP_MTLO))) begin
               lo_nxt = i_datoA;
            end
         end
         ST_MUL, ST_DIV: begin
            core_step = 1'b1;
            if (cnt_q == '0) state_nxt = ST_FIX;
            else             cnt_nxt   = cnt_q - CNT_W'(1);
         end
         ST_FIX: begin
            state_nxt = ST_IDLE;
            if (is_div_q) begin
               lo_nxt = neg_q_q ? -acc_lo : acc_lo;
               hi_nxt = neg_r_q ? -acc_hi : acc_hi;
            end else begin
               {hi_nxt, lo_nxt} = neg_q_q ? prod_neg : prod;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_q == ST_FIX);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         is_div_q <= is_div_nxt;
         neg_q_q  <= neg_q_nxt;
         neg_r_q  <= neg_r_nxt;
      end
   end

   assign o_hi    = hi_q;
   assign o_lo    = lo_q;
   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_stall = i_valid && busy_q && is_mdu_op(32'(i_opcode));

   always_comb begin
      o_result = '0;
      if      (i_opcode == N_OPCODE'(OP_MFHI)) o_result = hi_q;
      else if (i_opcode == N_OPCODE'(OP_MFLO)) o_result = lo_q;
   end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Multi-cycle multiply/divide unit with architectural HI/LO registers. It extends the combinational execute-stage ALU opcode space with MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the ALU in Execute and is parametrised in operand width. Long operations take N_BITS+1 cycles, and the pipeline stalls through `o_stall` while the unit is busy.

## Interface
- N_BITS, 32, operand/HI/LO width (even, ≥8)
- N_OPCODE, 6, opcode width, shared with the ALU opcode field
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  the opcode on i_opcode is an issued instruction this cycle
- i_opcode  in  N_OPCODE  operation select
- i_datoA  in  N_BITS  rs operand (dividend / multiplicand / MT source)
- i_datoB  in  N_BITS  rt operand (divisor / multiplier)
- o_hi  out  N_BITS  HI register
- o_lo  out  N_BITS  LO register
- o_result  out  N_BITS  MFHI/MFLO read data, combinational; 0 for other opcodes
- o_busy  out  1  long operation in flight
- o_done  out  1  one-cycle pulse, HI/LO just updated by a long operation
- o_stall  out  1  combinational: i_valid & o_busy & opcode in MDU set

## Operation
- Opcodes: MULT=20, MULTU=21, DIV=22, DIVU=23, MFHI=24, MFLO=25, MTHI=26, MTLO=27. Any other opcode is ignored by this unit.
- **States:** IDLE, MUL, DIV, FIX.
- **Accept:** a long op is accepted when i_valid, state==IDLE and the opcode is MULT, MULTU, DIV or DIVU.
  - Operands are latched as magnitudes for the signed ops.
  - The result sign flags are latched: product sign = A[msb]^B[msb]; quotient sign likewise; remainder sign = A[msb].
  - The counter is loaded with N_BITS-1.
- **MUL:** radix-2 shift-add on a 2·N_BITS accumulator, one multiplier bit per cycle. Leave when the counter reaches 0, moving to FIX.
- **DIV:** restoring division, one quotient bit per cycle. Leave when the counter reaches 0, moving to FIX.
- **FIX:** apply two's-complement correction per the sign flags, then write HI/LO at the end of the cycle and return to IDLE.
  - MUL result: HI = upper half, LO = lower half.
  - DIV result: LO = quotient, HI = remainder.
- **Divide by zero:** LO = all ones, HI = dividend (i_datoA as issued); the full latency still applies.
- **Signed overflow** (most-negative / -1): LO = most-negative, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- **MTHI/MTLO:** write i_datoA into HI/LO at the clock edge, only when state==IDLE. While busy they stall like any MDU opcode.
- **MFHI/MFLO:** o_result = o_hi / o_lo combinationally. While busy, o_stall is asserted and o_result still shows the old value; the consumer must not use it.
- While busy, i_valid with any MDU opcode is not accepted and raises o_stall. Non-MDU opcodes never stall.

## Timing
- **Reset** (sync, at a rising edge with i_reset=1):
  - state=IDLE, counter=0, HI=LO=0, o_busy=0, o_done=0.
  - Any in-flight operation is abandoned with no HI/LO write.
  - Reset has priority over accept.
- **Long-op latency:** accept at edge k.
  - o_busy is high in cycles k+1 … k+N_BITS+1 (N_BITS compute cycles plus FIX).
  - HI/LO update at edge k+N_BITS+1.
  - o_done is high for exactly the one cycle after that edge.
- **Back-to-back:** a new long op may be accepted in the o_done cycle, since the state is already IDLE. An MF* issued in that cycle reads the new HI/LO.
- **MTHI/MTLO:** one-edge latency; the new value is visible on o_hi/o_lo and via MF* in the next cycle.
- No internal back-pressure beyond o_stall. Inputs are sampled only at accept; operand changes during busy have no effect.

## Structure
- Package `alu_mdu_pkg`:
  - the eight opcode constants, contiguous with the ALU opcode space;
  - the state typedef (IDLE/MUL/DIV/FIX);
  - the `is_mdu_op` helper.
- Sub-module `mdu_seq_core`: shared shift register / accumulator datapath with add (MUL) or trial-subtract (DIV) per cycle. The top level holds the FSM, sign handling, HI/LO, and the MF/MT paths.

## Test plan
- **MULT:** A=-3 (0xFFFFFFFD), B=7 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_done one cycle.
- **MULTU:** A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- **DIV:** A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
- **Edge cases:**
  - DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
  - DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- **Stall:** MFLO issued 5 cycles after accepting MULT -> o_stall=1 until the o_done cycle, then o_result=new LO. MTLO A=0x1234 while busy -> LO unchanged. MTHI in IDLE -> o_hi=A next cycle.
- **Reset mid-operation:** i_reset at cycle 10 of a DIV -> HI=LO=0, o_busy=0, no o_done. Then MULT 6×7 completes normally with LO=42.
